// File: rtl/sol_judge_pkg.sv
// sol_judge_pkg: shared states, testcase codes and answer lookup for sol_judge.
package sol_judge_pkg;
   typedef enum logic [2:0] {IDLE, ARMED, COMPARE, SHOW_PASS, SHOW_FAIL, LOCKED} state_t;
   localparam logic [1:0] TC_NONE = 2'b00;
   localparam logic [1:0] TC1 = 2'b01;
   localparam logic [1:0] TC2 = 2'b10;
   localparam logic [1:0] TC3 = 2'b11;
   localparam logic [9:0] LED_ALL_ON = 10'h3FF;
   function automatic logic [9:0] answer_sel(input logic [1:0] tc, input logic [9:0] a1,
                                             input logic [9:0] a2, input logic [9:0] a3);
      return tc == TC1 ? a1 : tc == TC2 ? a2 : tc == TC3 ? a3 : '0;
   endfunction
endpackage

// File: rtl/sol_judge_hold_timer.sv
// hold_timer: loadable down-counter; o_done is high for the one cycle the loaded count reaches zero.
module hold_timer #(
   parameter int MAX = 4,
   parameter int W = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_done
);
   logic [W-1:0] r_cnt;
   logic         r_run;
   assign o_done = r_run && r_cnt == '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_val;
         r_run <= 1'b1;
      end else if (o_done) begin
         r_run <= 1'b0;
      end else if (r_run) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/sol_judge.sv
// sol_judge: arms a puzzle stage, judges its solution and shows pass/fail on the LEDs.
// Optional SOL_JUDGE_BLINK_EN blinks the mismatch mask during a failed result.
module sol_judge
   import sol_judge_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int BLINK_PERIOD = 12_500_000,
   parameter int MAX_TRIES = 3,
   parameter logic [9:0] ANS_TC1 = 10'b0000111111,
   parameter logic [9:0] ANS_TC2 = 10'b0011110000,
   parameter logic [9:0] ANS_TC3 = 10'b1110000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] testcase,
   input  logic       is_finish,
   input  logic [9:0] my_sol,
   output logic       stage_en,
   output logic       result_valid,
   output logic       pass,
   output logic [1:0] tries_left,
   output logic [3:0] score,
   output logic       busy,
   output logic [9:0] led
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   state_t     r_state;
   logic [1:0] r_tc, r_tries;
   logic [9:0] r_sol, r_led;
   logic [3:0] r_score;
   logic       r_fin, r_armed, r_stage_en, r_valid, r_pass, r_busy;
   logic [9:0] w_ans, w_mask;
   logic       w_match, w_start_ok, w_edge, w_hold_done, w_blink;
   assign w_ans = answer_sel(r_tc, ANS_TC1, ANS_TC2, ANS_TC3);
   assign w_mask = r_sol ^ w_ans;
   assign w_match = r_sol == w_ans;
   assign w_start_ok = start && testcase != TC_NONE && (r_state == IDLE || r_state == LOCKED);
   // r_armed blocks acceptance until r_fin holds a sample taken while the stage was enabled
   assign w_edge = r_state == ARMED && r_armed && is_finish && !r_fin;
   hold_timer #(.MAX(HOLD_CYCLES)) u_hold (
      .clk(clk), .reset(reset), .i_load(r_state == COMPARE),
      .i_val(HW'(HOLD_CYCLES - 1)), .o_done(w_hold_done)
   );
`ifdef SOL_JUDGE_BLINK_EN
   localparam int BW = $clog2(BLINK_PERIOD + 1);
   logic w_blink_done;
   hold_timer #(.MAX(BLINK_PERIOD)) u_blink (
      .clk(clk), .reset(reset),
      .i_load(r_state == COMPARE || (r_state == SHOW_FAIL && w_blink_done)),
      .i_val(BW'(BLINK_PERIOD - 1)), .o_done(w_blink_done)
   );
   assign w_blink = w_blink_done;
`else
   assign w_blink = BLINK_PERIOD < 1;  // never true for a legal BLINK_PERIOD
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_tc <= '0;
         r_tries <= '0;
         r_sol <= '0;
         r_led <= '0;
         r_score <= '0;
         r_fin <= 1'b0;
         r_armed <= 1'b0;
         r_stage_en <= 1'b0;
         r_valid <= 1'b0;
         r_pass <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_armed <= r_state == ARMED;
         r_fin <= r_stage_en ? is_finish : 1'b0;
         case (r_state)
            IDLE, LOCKED: if (w_start_ok) begin
               r_tc <= testcase;
               r_tries <= 2'(MAX_TRIES);
               r_pass <= 1'b0;
               r_stage_en <= 1'b1;
               r_busy <= 1'b1;
               r_state <= ARMED;
            end
            ARMED: if (w_edge) begin
               r_sol <= my_sol;
               r_stage_en <= 1'b0;
               r_state <= COMPARE;
            end
            COMPARE: begin
               r_valid <= 1'b1;
               r_pass <= w_match;
               r_led <= w_match ? LED_ALL_ON : w_mask;
               r_score <= w_match && r_score != 4'hF ? r_score + 1'b1 : r_score;
               r_tries <= w_match ? r_tries : r_tries - 1'b1;
               r_state <= w_match ? SHOW_PASS : SHOW_FAIL;
            end
            SHOW_PASS: if (w_hold_done) begin
               r_led <= '0;
               r_busy <= 1'b0;
               r_state <= IDLE;
            end
            SHOW_FAIL: if (w_hold_done) begin
               r_led <= '0;
               r_stage_en <= r_tries != '0;
               r_busy <= r_tries != '0;
               r_state <= r_tries != '0 ? ARMED : LOCKED;
            end else if (w_blink) begin
               r_led <= r_led != '0 ? '0 : w_mask;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign stage_en = r_stage_en;
   assign result_valid = r_valid;
   assign pass = r_pass;
   assign tries_left = r_tries;
   assign score = r_score;
   assign busy = r_busy;
   assign led = r_led;
endmodule

// File: doc/sol_judge.md
# sol_judge

Downstream judge for a puzzle-stage block. It arms the stage for a selected testcase and waits for the stage to report completion. It then compares the stage's accumulated 10-bit switch solution against the answer mask for that testcase, shows a pass/fail pattern on the LEDs for a fixed hold time, and tracks remaining tries and a saturating score. It drives the stage's enable, so dropping enable is how the stage gets cleared between attempts.

## Interface
- HOLD_CYCLES, 50_000_000: length of the result display in clk cycles (≥2; benches use 4).
- BLINK_PERIOD, 12_500_000: half-period of the fail blink in cycles (≥1; benches use 1).
- MAX_TRIES, 3: attempts per arming (1–3).
- ANS_TC1, 10'b0000111111: answer for testcase 2'b01.
- ANS_TC2, 10'b0011110000: answer for testcase 2'b10.
- ANS_TC3, 10'b1110000000: answer for testcase 2'b11.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to arm the testcase on `testcase`.
- testcase  in  2  testcase select; 2'b00 is invalid.
- is_finish  in  1  level from stage: required press count reached.
- my_sol  in  10  stage's accumulated solution.
- stage_en  out  1  enable to the stage; low clears it.
- result_valid  out  1  one-cycle pulse when a comparison completes.
- pass  out  1  result of the last comparison; held until the next start.
- tries_left  out  2  remaining attempts.
- score  out  4  count of passes, saturating at 15.
- busy  out  1  high in any state other than IDLE or LOCKED.
- led  out  10  result display.

## Operation
- States: IDLE, ARMED, COMPARE, SHOW_PASS, SHOW_FAIL, LOCKED.
- Reset values: state IDLE, stage_en 0, result_valid 0, pass 0, tries_left 0, score 0, busy 0, led 0. Internal tc_q, sol_q and fin_q are also 0.
- IDLE or LOCKED + start with testcase≠0:
  - latch tc_q;
  - set tries_left=MAX_TRIES;
  - clear pass;
  - go to ARMED.
- start with testcase=0 is ignored.
- start is ignored in all other states.
- ARMED:
  - stage_en=1.
  - fin_q registers is_finish every cycle. fin_q is forced to 0 whenever stage_en=0.
  - is_finish=1 with fin_q=0 is a rising edge: latch sol_q=my_sol, go to COMPARE.
- COMPARE (one cycle):
  - stage_en=0.
  - match = (sol_q == answer(tc_q)); exact 10-bit equality.
  - match: score+1, saturating at 15; go to SHOW_PASS.
  - no match: tries_left−1; go to SHOW_FAIL.
  - pass=match; result_valid=1 on the cycle of entry to the SHOW state.
- SHOW_PASS: led=10'h3FF for HOLD_CYCLES cycles, then go to IDLE with led=0.
- SHOW_FAIL:
  - led = sol_q ^ answer(tc_q), which shows the mismatched bits.
  - After HOLD_CYCLES cycles: go to ARMED if tries_left>0, otherwise go to LOCKED.
- LOCKED: led=10'h000. Exit only on a valid start.
- stage_en is low in every state except ARMED. The stage therefore always sees at least HOLD_CYCLES+1 cycles of enable low between attempts.
- Reset mid-operation: immediate return to all reset values. score is lost.

## Timing
- Start sampled at cycle 0 → ARMED and stage_en=1 at cycle 1.
- An is_finish edge is accepted no earlier than cycle 2, because fin_q needs one armed cycle.
- is_finish edge sampled at cycle N → COMPARE at N+1 (stage_en=0 from N+1).
- At N+2: SHOW state entered, result_valid pulse, and pass, score and tries_left updated.
- led valid from N+2 through N+1+HOLD_CYCLES; state leaves SHOW at N+2+HOLD_CYCLES.
- All outputs are registered; there are no combinational paths from input to output.
- If is_finish is already high on entry to ARMED (stage not yet cleared), it is not accepted until it falls and rises again.

## Configuration
- SOL_JUDGE_BLINK_EN defined: in SHOW_FAIL, led alternates between the mismatch mask and 0, toggling every BLINK_PERIOD cycles. The phase starts with the mask visible.
- Not defined: the mismatch mask is shown statically for the whole hold. BLINK_PERIOD is unused.
- Defining the macro has no effect on any other output or on any timing.

## Structure
- Package sol_judge_pkg contains:
  - state enum;
  - testcase codes TC_NONE, TC1, TC2, TC3;
  - LED_ALL_ON constant;
  - the answer-select function.
- Sub-module hold_timer:
  - loadable down-counter with a done pulse;
  - used for HOLD_CYCLES;
  - a second instance is used for BLINK_PERIOD under the macro.

## Test plan
- Pass path: start, tc=01 → stage_en=1 at cycle 1 → my_sol=10'b0000111111 and is_finish rise at cycle 5 → result_valid at cycle 7, pass=1, score=1, led=3FF for 4 cycles → IDLE, led=0.
- Fail path: tc=10, my_sol=10'b0011110001 → pass=0, tries_left=2, led=10'b0000000001. With blink on, led toggles each cycle. → ARMED again, stage_en=1.
- Lockout: tc=11 with three wrong solutions → tries_left=0, LOCKED, stage_en=0. Extra is_finish pulses are ignored. A valid start re-arms with tries_left=3.
- Invalid and busy starts: start with tc=00 in IDLE → stays IDLE. start during ARMED or SHOW → no change to tc_q or tries_left.
- Stale finish: is_finish held high through arming → no acceptance. It falls, then rises → accepted two cycles later.
- Saturation and reset: 16 consecutive passes → score=15. Async reset asserted mid-SHOW_PASS → all outputs 0 immediately, without waiting for a clk edge.
